frame_tx_serializer: RTL and testbench

//  Upstream transmitter for the MINIsampler serial link: packs one 21-bit payload

---
 rtl/frame_tx_serializer.sv | 211 +++++++++++++++++++++
 tb/tb_frame_tx_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : frame_tx_serializer
// Purpose  : Packs a 21-bit payload into three tagged UART-style frames and
//            shifts them out on one line at BIT_CYCLES clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module frame_tx_serializer #(
  parameter int BIT_CYCLES = 128,
  parameter int GAP_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        serial_out,
  output logic        busy,
  output logic [1:0]  frame_idx,
  output logic        done
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [CW-1:0] C_CYC_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] C_CYC_PENULT = CW'(BIT_CYCLES - 2);
  localparam logic [GW-1:0] C_GAP_LAST   = GW'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      frame_q, frame_d;
  logic [20:0]     data_q, data_d;
  logic            serial_q, serial_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [1:0]      idx_q, idx_d;
  logic            done_q, done_d;

  logic [7:0]      w_byte;
  logic            w_bit_end;
  logic            w_accept;

  assign w_bit_end = (cyc_q == C_CYC_LAST);
  assign w_accept  = tx_valid & ready_q;

  // Frame 0 carries the tag bit set; it goes out last since bytes are LSB first.
  always_comb begin
    case (frame_q)
      2'd0:    w_byte = {1'b1, data_q[6:0]};
      2'd1:    w_byte = {1'b0, data_q[13:7]};
      default: w_byte = {1'b0, data_q[20:14]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    frame_d  = frame_q;
    data_d   = data_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    if (state_q != S_IDLE) begin
      cyc_d = w_bit_end ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        if (w_accept) begin
          data_d   = tx_data;
          state_d  = S_START;
          cyc_d    = '0;
          bit_d    = 3'd0;
          gap_d    = '0;
          frame_d  = 2'd0;
          idx_d    = 2'd0;
          serial_d = 1'b0;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          state_d  = S_DATA;
          bit_d    = 3'd0;
          serial_d = w_byte[0];
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (bit_q == 3'd7) begin
            state_d  = S_STOP;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = w_byte[bit_q + 3'd1];
          end
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          state_d  = S_GAP;
          gap_d    = '0;
          serial_d = 1'b1;
        end
      end

      S_GAP: begin
        // Registered done/ready must be set one cycle ahead of the final gap cycle.
        if (frame_q == 2'd2 && gap_q == C_GAP_LAST && cyc_q == C_CYC_PENULT) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
        if (w_bit_end) begin
          if (gap_q != C_GAP_LAST) begin
            gap_d = gap_q + 1'b1;
          end else if (frame_q != 2'd2) begin
            state_d  = S_START;
            frame_d  = frame_q + 2'd1;
            idx_d    = frame_q + 2'd1;
            serial_d = 1'b0;
          end else if (w_accept) begin
            data_d   = tx_data;
            state_d  = S_START;
            cyc_d    = '0;
            bit_d    = 3'd0;
            gap_d    = '0;
            frame_d  = 2'd0;
            idx_d    = 2'd0;
            serial_d = 1'b0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
          end else begin
            state_d  = S_IDLE;
            cyc_d    = '0;
            gap_d    = '0;
            frame_d  = 2'd0;
            idx_d    = 2'd0;
            serial_d = 1'b1;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
        ready_d  = 1'b1;
        idx_d    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= 3'd0;
      gap_q    <= '0;
      frame_q  <= 2'd0;
      data_q   <= 21'd0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      idx_q    <= 2'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready   = ready_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign frame_idx  = idx_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_tx_serializer
// Purpose  : Self-checking bench for frame_tx_serializer against a slot-level
//            line model built from the packet bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_tx_serializer;

  localparam int BC  = 4;
  localparam int G   = 2;
  localparam int FB  = 10 + G;
  localparam int LEN = 3 * FB * BC;

  logic        clk;
  logic        rst;
  logic [20:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        serial_out;
  logic        busy;
  logic [1:0]  frame_idx;
  logic        done;

  int total = 0;
  int bad   = 0;

  frame_tx_serializer #(.BIT_CYCLES(BC), .GAP_BITS(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_idx  (frame_idx),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input logic [20:0] d, input int f);
    logic [20:0] s;
    s = d >> (7 * f);
    return {(f == 0) ? 1'b1 : 1'b0, s[6:0]};
  endfunction

  // Called at a negedge with the DUT able to accept; returns at the negedge of the done cycle.
  task automatic send(input logic [20:0] d, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input bit b2b, input logic [20:0] nd,
                      input bit glitch);
    logic [7:0] bytes [3];
    int f, slot;
    logic eb;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      f    = k / (FB * BC);
      slot = (k % (FB * BC)) / BC;
      if (slot == 0)      eb = 1'b0;
      else if (slot <= 8) eb = bytes[f][slot-1];
      else                eb = 1'b1;
      chk("serial", {31'd0, serial_out}, {31'd0, eb});
      chk("done",   {31'd0, done},       {31'd0, k == LEN - 1});
      chk("ready",  {31'd0, tx_ready},   {31'd0, k == LEN - 1});
      chk("busy",   {31'd0, busy},       32'd1);
      chk("idx",    {30'd0, frame_idx},  f[31:0]);
      if (k == 0) begin
        if (b2b) tx_data = nd;
        else     tx_valid = 1'b0;
      end
      if (glitch && k == LEN / 2) begin
        tx_valid = 1'b1;
        tx_data  = 21'($urandom);
      end
      if (glitch && k == LEN / 2 + 1) tx_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_serial"}, {31'd0, serial_out}, 32'd1);
    chk({tag, "_ready"},  {31'd0, tx_ready},   32'd1);
    chk({tag, "_busy"},   {31'd0, busy},       32'd0);
    chk({tag, "_done"},   {31'd0, done},       32'd0);
    chk({tag, "_idx"},    {30'd0, frame_idx},  32'd0);
  endtask

  initial begin
    logic [20:0] cur, nxt, d1, d2;
    bit          b2b;

    // Reset held with a concurrent offer: nothing may be accepted.
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 21'h1F0F0F;
    repeat (3) @(negedge clk);
    chk("rst_serial", {31'd0, serial_out}, 32'd1);
    chk("rst_ready",  {31'd0, tx_ready},   32'd1);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_idx",    {30'd0, frame_idx},  32'd0);
    chk("rst_done",   {31'd0, done},       32'd0);
    tx_valid = 1'b0;
    rst      = 1'b0;
    check_idle("post_rst");

    // Directed: known payloads with hand-derived frame bytes.
    send(21'h15A5A5, 8'hA5, 8'h4B, 8'h56, 1'b0, 21'd0, 1'b0);
    check_idle("basic");
    send(21'h000000, 8'h80, 8'h00, 8'h00, 1'b0, 21'd0, 1'b0);
    check_idle("tag");

    // Back-to-back with tx_valid held high through both packets.
    d1 = 21'h0ABCDE;
    d2 = 21'h1357F1;
    send(d1, pkt_byte(d1, 0), pkt_byte(d1, 1), pkt_byte(d1, 2), 1'b1, d2, 1'b0);
    send(d2, pkt_byte(d2, 0), pkt_byte(d2, 1), pkt_byte(d2, 2), 1'b0, 21'd0, 1'b0);
    check_idle("b2b");

    // Mid-packet offer must neither corrupt this packet nor queue another.
    d1 = 21'h0F00F5;
    send(d1, pkt_byte(d1, 0), pkt_byte(d1, 1), pkt_byte(d1, 2), 1'b0, 21'd0, 1'b1);
    check_idle("ignored");
    for (int i = 0; i < 2 * BC; i++) begin
      @(negedge clk);
      chk("no_second_busy", {31'd0, busy}, 32'd0);
    end

    // Asynchronous reset in the middle of frame 1 data.
    tx_valid = 1'b1;
    tx_data  = 21'h1ABCDE;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (FB * BC + 3 * BC) @(negedge clk);
    chk("pre_rst_idx",  {30'd0, frame_idx}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy},      32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_serial", {31'd0, serial_out}, 32'd1);
    chk("arst_ready",  {31'd0, tx_ready},   32'd1);
    chk("arst_busy",   {31'd0, busy},       32'd0);
    chk("arst_idx",    {30'd0, frame_idx},  32'd0);
    chk("arst_done",   {31'd0, done},       32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3 * BC; i++) begin
      @(negedge clk);
      chk("arst_quiet_done",   {31'd0, done},       32'd0);
      chk("arst_quiet_serial", {31'd0, serial_out}, 32'd1);
    end

    // Randomized payloads, mixing idle spacing and back-to-back handover.
    cur = 21'($urandom);
    for (int i = 0; i < 8; i++) begin
      nxt = 21'($urandom);
      b2b = (i < 7) && ($urandom_range(0, 1) == 1);
      send(cur, pkt_byte(cur, 0), pkt_byte(cur, 1), pkt_byte(cur, 2), b2b, nxt, 1'b0);
      if (!b2b) begin
        check_idle("rand");
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      cur = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
